// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the sync/blank decode used by the timing generator.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_RESET = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

    // Syncs are active-low; blank=1 means the pixel is visible.
    function automatic vga_ctrl_t decode_ctrl(input logic [9:0] x, input logic [9:0] y);
        vga_ctrl_t c;
        c.hs    = !((x >= H_SYNC_START) && (x <= H_SYNC_END));
        c.vs    = !((y >= V_SYNC_START) && (y <= V_SYNC_END));
        c.blank = (x < H_VIS_END) && (y < V_VIS_END);
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, 800x525 raster counters and registered sync/blank.
// Reset asserts asynchronously; release passes through a two-flop synchroniser.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       pixel_clk,
    output logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start
);

    localparam int unsigned DIV_W = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIX_DIV / 2);

    logic [1:0]       sync_q;
    logic             running;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    vga_ctrl_t        ctrl_q, ctrl_d;
    logic             pclk_q, pclk_d;
    logic             fs_q, fs_d;
    logic             pix_en_w;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign running  = sync_q[1];
    assign pix_en_w = running && (div_q == DIV_MAX);

    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        if (!running || pix_en_w) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        if (pix_en_w) begin
            if (x_q == H_MAX) begin
                x_d = 10'd0;
                y_d = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Decoding the next-state counters lets the registered controls line up with DrawX/DrawY.
    always_comb begin
        ctrl_d = decode_ctrl(x_d, y_d);
        fs_d   = pix_en_w && (x_q == H_MAX) && (y_q == V_MAX);
        // sync_q[0] predicts whether the divider runs in the coming cycle.
        pclk_d = sync_q[0] && (div_d < DIV_HALF);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q  <= '0;
            x_q    <= 10'd0;
            y_q    <= 10'd0;
            ctrl_q <= CTRL_RESET;
            pclk_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            x_q    <= x_d;
            y_q    <= y_d;
            ctrl_q <= ctrl_d;
            pclk_q <= pclk_d;
            fs_q   <= fs_d;
        end
    end

    assign pixel_clk   = pclk_q;
    assign pix_en      = pix_en_w;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = ctrl_q.hs;
    assign vs          = ctrl_q.vs;
    assign blank       = ctrl_q.blank;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (PIX_DIV 2 and 4) checked every Clk against a
// pixel-index reference model; raster position is jumped by force/release to reach far lines.
module tb_vga_timing_gen;

    localparam int unsigned FRAME_PIX = 800 * 525;
    localparam int unsigned DIV0 = 2;
    localparam int unsigned DIV1 = 4;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b1;
    logic [1:0]      pclk, pen, hs, vs, blank, fs;
    logic [1:0][9:0] dx, dy;

    vga_timing_gen #(.PIX_DIV(DIV0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(pclk[0]), .pix_en(pen[0]),
        .DrawX(dx[0]), .DrawY(dy[0]), .hs(hs[0]), .vs(vs[0]), .blank(blank[0]),
        .frame_start(fs[0])
    );

    vga_timing_gen #(.PIX_DIV(DIV1)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(pclk[1]), .pix_en(pen[1]),
        .DrawX(dx[1]), .DrawY(dy[1]), .hs(hs[1]), .vs(vs[1]), .blank(blank[1]),
        .frame_start(fs[1])
    );

    always #5 Clk = ~Clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: absolute pixel index within the frame plus Clk phase within the pixel.
    int unsigned div_of [2] = '{DIV0, DIV1};
    int unsigned phase [2];
    int unsigned pidx [2];
    bit          fs_exp [2];
    bit          skip [2];
    bit          run;
    int unsigned sync_cnt;
    logic [9:0]  xf, yf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        run = 1'b0;
        sync_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            phase[k] = 0; pidx[k] = 0; fs_exp[k] = 1'b0; skip[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!Reset_n) begin
            model_reset();
        end else if (!run) begin
            sync_cnt++;
            if (sync_cnt == 2) run = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                fs_exp[k] = 1'b0;
                if (phase[k] == div_of[k] - 1) begin
                    phase[k] = 0;
                    skip[k] = 1'b0;
                    pidx[k] = (pidx[k] + 1) % FRAME_PIX;
                    if (pidx[k] == 0) fs_exp[k] = 1'b1;
                end else begin
                    phase[k]++;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            int unsigned x, y;
            string t;
            x = pidx[k] % 800;
            y = pidx[k] / 800;
            t = $sformatf("%s.d%0d", tag, div_of[k]);
            chk({t, ".DrawX"}, 32'(dx[k]), x);
            chk({t, ".DrawY"}, 32'(dy[k]), y);
            chk({t, ".pix_en"}, 32'(pen[k]), 32'(run && phase[k] == div_of[k] - 1));
            chk({t, ".pixel_clk"}, 32'(pclk[k]), 32'(run && phase[k] < div_of[k] / 2));
            chk({t, ".frame_start"}, 32'(fs[k]), 32'(fs_exp[k]));
            if (!skip[k]) begin
                chk({t, ".hs"}, 32'(hs[k]), 32'(!(x >= 656 && x <= 751)));
                chk({t, ".vs"}, 32'(vs[k]), 32'(!(y >= 490 && y <= 491)));
                chk({t, ".blank"}, 32'(blank[k]), 32'(x < 640 && y < 480));
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_outputs(tag);
    endtask

    task automatic run_ticks(input int unsigned n, input string tag);
        for (int i = 0; i < int'(n); i++) tick(tag);
    endtask

    // Jump one instance's raster position; its sync/blank registers catch up on the next pixel.
    task automatic inject(input int unsigned k, input int unsigned xv, input int unsigned yv);
        xf = 10'(xv);
        yf = 10'(yv);
        if (k == 0) begin
            force dut.x_q = xf;
            force dut.y_q = yf;
        end else begin
            force dut4.x_q = xf;
            force dut4.y_q = yf;
        end
        pidx[k] = yv * 800 + xv;
        skip[k] = 1'b1;
        #1;
        if (k == 0) begin
            release dut.x_q;
            release dut.y_q;
        end else begin
            release dut4.x_q;
            release dut4.y_q;
        end
    endtask

    initial begin
        #5_000_000;
        $fatal(1, "FAIL watchdog: simulation exceeded its time budget");
    end

    initial begin
        int unsigned first_pen [2];
        int          first_hs, first_blank_lo;
        int unsigned hs_cyc, fs_cnt, found, px, py;
        int unsigned hi_cnt [2];
        int unsigned en_cnt [2];
        int unsigned edge_lines [10] = '{478, 479, 480, 488, 489, 490, 491, 492, 523, 524};

        model_reset();
        #2 Reset_n = 1'b0;
        run_ticks(5, "reset");

        // Release: two sync edges, then PIX_DIV-1 divider steps before the first pix_en.
        Reset_n = 1'b1;
        first_pen = '{0, 0};
        for (int i = 1; i <= 12; i++) begin
            tick("release");
            for (int k = 0; k < 2; k++) begin
                if (first_pen[k] == 0 && pen[k]) first_pen[k] = i;
            end
        end
        chk("release.first_pix_en.d2", first_pen[0], DIV0 + 1);
        chk("release.first_pix_en.d4", first_pen[1], DIV1 + 1);

        hs_cyc = 0; first_hs = -1; first_blank_lo = -1;
        for (int i = 0; i < 1700 && dy[0] == 10'd0; i++) begin
            tick("line");
            if (dy[0] == 10'd0) begin
                if (!hs[0]) begin
                    hs_cyc++;
                    if (first_hs < 0) first_hs = int'(dx[0]);
                end
                if (!blank[0] && first_blank_lo < 0) first_blank_lo = int'(dx[0]);
            end
        end
        chk("line.hs_low_clks", hs_cyc, 96 * DIV0);
        chk("line.hs_first_x", 32'(first_hs), 656);
        chk("line.blank_fall_x", 32'(first_blank_lo), 640);
        chk("line.next_y", 32'(dy[0]), 1);
        chk("line.blank_rise", 32'(blank[0]), 1);

        for (int i = 0; i < 10; i++) begin
            inject(0, 790, edge_lines[i]);
            inject(1, 795, edge_lines[i]);
            run_ticks(40, "vert");
        end

        inject(0, 797, 524);
        inject(1, 797, 524);
        found = 0; px = 0; py = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            px = dx[0]; py = dy[0];
            tick("wrap");
            if (fs[0]) begin
                found = 1;
                chk("wrap.prev_x", px, 799);
                chk("wrap.prev_y", py, 524);
                chk("wrap.x", 32'(dx[0]), 0);
                chk("wrap.y", 32'(dy[0]), 0);
            end
        end
        chk("wrap.seen", found, 1);
        tick("wrap");
        chk("wrap.fs_single_clk", 32'(fs[0]), 0);
        run_ticks(30, "wrap.after");

        for (int n = 0; n < 8; n++) begin
            int unsigned k, xv, yv;
            k = $urandom_range(1, 0);
            xv = $urandom_range(799, 0);
            if ($urandom_range(1, 0) == 1) yv = edge_lines[$urandom_range(9, 0)];
            else yv = $urandom_range(524, 0);
            inject(k, xv, yv);
            run_ticks($urandom_range(600, 50), "random");
        end

        inject(0, 297, 200);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick("midrst.pre");
            if (dx[0] == 10'd300) found = 1;
        end
        chk("midrst.reach", found, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("midrst.x_async", 32'(dx[0]), 0);
        chk("midrst.y_async", 32'(dy[0]), 0);
        model_reset();
        check_outputs("midrst.async");
        run_ticks(3, "midrst.hold");
        Reset_n = 1'b1;
        fs_cnt = 0;
        for (int i = 0; i < 3300; i++) begin
            tick("midrst.run");
            if (fs[0] || fs[1]) fs_cnt++;
        end
        chk("midrst.no_frame_start", fs_cnt, 0);

        hi_cnt = '{0, 0};
        en_cnt = '{0, 0};
        for (int i = 0; i < 40; i++) begin
            tick("duty");
            for (int k = 0; k < 2; k++) begin
                if (pclk[k]) hi_cnt[k]++;
                if (pen[k]) en_cnt[k]++;
            end
        end
        chk("duty.pclk_high.d2", hi_cnt[0], 20);
        chk("duty.pclk_high.d4", hi_cnt[1], 20);
        chk("duty.pix_en.d2", en_cnt[0], 40 / DIV0);
        chk("duty.pix_en.d4", en_cnt[1], 40 / DIV1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
